// File: rtl/traffic_sensor_cond_pkg.sv
// Shared constants and types for the traffic sensor conditioner and the
// light controller that consumes its TA/TB flags.
package traffic_sensor_cond_pkg;

  localparam int unsigned CNT_W            = 8;
  localparam int unsigned DEBOUNCE_DEFAULT = 4;
  localparam int unsigned HOLD_DEFAULT     = 8;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/traffic_sensor_cond_if.sv
// Sensor-side bundle: raw street sensors in, conditioned flags and rise pulses out.
interface traffic_sensor_cond_if;

  logic sa_raw;
  logic sb_raw;
  logic TA;
  logic TB;
  logic ta_rise;
  logic tb_rise;

  modport master (
    output sa_raw,
    output sb_raw,
    input  TA,
    input  TB,
    input  ta_rise,
    input  tb_rise
  );

  modport slave (
    input  sa_raw,
    input  sb_raw,
    output TA,
    output TB,
    output ta_rise,
    output tb_rise
  );

endinterface

// File: rtl/sensor_channel.sv
// One sensor channel: two-flop synchronizer, run-length debounce,
// post-drop hold stretch and a one-cycle rise pulse.
module sensor_channel
  import traffic_sensor_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned HOLD_CYCLES     = HOLD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic t,
  output logic rise
);

  localparam cnt_t DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  logic sync1;
  logic sync2;
  logic deb;
  logic deb_d;
  cnt_t deb_cnt;
  cnt_t hold_cnt;
  logic deb_flip_c;

  // Debounced level changes on the edge the differing run reaches its length.
  assign deb_flip_c = (sync2 != deb) && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (sync2 == deb) begin
      deb_cnt <= '0;
    end else if (deb_flip_c) begin
      deb     <= sync2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

  // Hold loads on the falling flip, is cancelled by a rising flip, else drains to 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (deb_flip_c && deb) begin
      hold_cnt <= HOLD_LOAD;
    end else if (deb_flip_c) begin
      hold_cnt <= '0;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      t     <= 1'b0;
      deb_d <= 1'b0;
      rise  <= 1'b0;
    end else begin
      t     <= deb | (hold_cnt != '0);
      deb_d <= deb;
      rise  <= deb & ~deb_d;
    end
  end

endmodule

// File: rtl/traffic_sensor_cond.sv
// Traffic sensor conditioner top: two independent sensor channels, wiring only.
module traffic_sensor_cond
  import traffic_sensor_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned HOLD_CYCLES     = HOLD_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  traffic_sensor_cond_if.slave bus
);

  sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES)
  ) u_chan_a (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sa_raw),
    .t     (bus.TA),
    .rise  (bus.ta_rise)
  );

  sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES)
  ) u_chan_b (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sb_raw),
    .t     (bus.TB),
    .rise  (bus.tb_rise)
  );

endmodule
